// File: rtl/nor_reduce_pkg.sv
// Shared encodings and elaboration-time helpers for the pipelined OR-reduction tree.
// Level 0 is the operand itself; level L holds the group ORs produced by tree stage L.
package nor_reduce_pkg;

    typedef enum logic [1:0] {
        MODE_NOR    = 2'b00,
        MODE_OR     = 2'b01,
        MODE_STICKY = 2'b10,
        MODE_RSVD   = 2'b11
    } mode_e;

    typedef struct packed {
        mode_e mode;
        logic  clr;
    } side_t;

    // Number of tree levels needed to fold width bits down to one: ceil(log_fanin(width)).
    function automatic int calc_stages(input int width, input int fanin);
        int w;
        int n;
        w = width;
        n = 0;
        while (w > 1) begin
            w = (w + fanin - 1) / fanin;
            n++;
        end
        return n;
    endfunction

    function automatic int level_width(input int width, input int fanin, input int level);
        int w;
        w = width;
        for (int i = 0; i < level; i++) begin
            w = (w + fanin - 1) / fanin;
        end
        return w;
    endfunction

    // Bit offset of a level inside the flattened tree bus (levels packed LSB-first).
    function automatic int level_offset(input int width, input int fanin, input int level);
        int off;
        off = 0;
        for (int i = 0; i < level; i++) begin
            off += level_width(width, fanin, i);
        end
        return off;
    endfunction

endpackage

// File: rtl/nor_reduce_stage.sv
// One registered level of the reduction tree: ORs groups of FANIN bits (zero-padded)
// and forwards the operand's sideband, with a skid-free valid/ready handshake.
module nor_reduce_stage
    import nor_reduce_pkg::*;
#(
    parameter int IN_W  = 32,
    parameter int FANIN = 4,
    localparam int OUT_W = (IN_W + FANIN - 1) / FANIN
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [IN_W-1:0]  data_i,
    input  side_t            side_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [OUT_W-1:0] data_o,
    output side_t            side_o
);

    logic [OUT_W*FANIN-1:0] padded;
    logic [OUT_W-1:0]       data_d;
    logic [OUT_W-1:0]       data_q;
    side_t                  side_q;
    logic                   valid_q;

    // NOTE: every signal written here gets a default first, so no latch can be inferred.
    always_comb begin
        padded             = '0;
        padded[IN_W-1:0]   = data_i;
        data_d             = '0;
        for (int g = 0; g < OUT_W; g++) begin
            data_d[g] = |padded[g*FANIN +: FANIN];
        end
    end

    assign in_ready_o = !valid_q || out_ready_i;

    // NOTE: sequential state uses non-blocking assignments so all stages update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            // NOTE: the sideband is reset as well so Y_MODE reads 00 while the pipe is empty.
            data_q  <= '0;
            side_q  <= '{mode: MODE_NOR, clr: 1'b0};
        end else if (in_ready_o) begin
            valid_q <= in_valid_i;
            if (in_valid_i) begin
                data_q <= data_d;
                side_q <= side_i;
            end
        end
    end

    assign out_valid_o = valid_q;
    assign data_o      = data_q;
    assign side_o      = side_q;

endmodule

// File: rtl/nor_reduce_pipe.sv
// Pipelined WIDTH-bit NOR/OR reduction with a sticky-NOR accumulator at the output.
// The tree is a chain of nor_reduce_stage levels sharing one flattened data bus.
module nor_reduce_pipe
    import nor_reduce_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int FANIN = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [WIDTH-1:0] A,
    input  logic [1:0]       MODE,
    input  logic             IN_CLR,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic             Y,
    output logic [1:0]       Y_MODE
);

    localparam int STAGES = calc_stages(WIDTH, FANIN);
    localparam int TOTAL  = level_offset(WIDTH, FANIN, STAGES + 1);

    logic [TOTAL-1:0] tree;
    logic [STAGES:0]  vld;
    logic [STAGES:0]  rdy;
    side_t            side [STAGES+1];

    assign tree[WIDTH-1:0] = A;
    assign vld[0]          = IN_VALID;
    assign side[0]         = '{mode: mode_e'(MODE), clr: IN_CLR};
    assign IN_READY        = rdy[0];
    assign rdy[STAGES]     = OUT_READY;

    for (genvar s = 0; s < STAGES; s++) begin : g_level
        localparam int IW    = level_width(WIDTH, FANIN, s);
        localparam int OW    = level_width(WIDTH, FANIN, s + 1);
        localparam int OFF_I = level_offset(WIDTH, FANIN, s);
        localparam int OFF_O = level_offset(WIDTH, FANIN, s + 1);

        nor_reduce_stage #(
            .IN_W  (IW),
            .FANIN (FANIN)
        ) u_stage (
            .clk         (CLK),
            .rst         (RST),
            .in_valid_i  (vld[s]),
            .in_ready_o  (rdy[s]),
            .data_i      (tree[OFF_I +: IW]),
            .side_i      (side[s]),
            .out_valid_o (vld[s+1]),
            .out_ready_i (rdy[s+1]),
            .data_o      (tree[OFF_O +: OW]),
            .side_o      (side[s+1])
        );
    end

    // The last level is a single bit: the OR of the whole operand.
    logic  r;
    side_t side_out;
    logic  y_raw;
    logic  acc_d;
    logic  acc_q;

    assign r        = tree[TOTAL-1];
    assign side_out = side[STAGES];

    always_comb begin
        y_raw = ~r;
        case (side_out.mode)
            MODE_OR:     y_raw = r;
            MODE_STICKY: y_raw = side_out.clr ? ~r : (acc_q & ~r);
            default:     y_raw = ~r;
        endcase
    end

    // ACC only moves on an accepted result, so a stalled output stays stable.
    always_comb begin
        acc_d = acc_q;
        if (OUT_VALID && OUT_READY) begin
            if (side_out.mode == MODE_STICKY) begin
                acc_d = y_raw;
            end else if (side_out.clr) begin
                acc_d = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            acc_q <= 1'b1;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign OUT_VALID = vld[STAGES];
    assign Y         = OUT_VALID & y_raw;
    assign Y_MODE    = side_out.mode;

endmodule

// File: tb/tb_nor_reduce_pipe.sv
// Directed self-checking bench for nor_reduce_pipe (default 32/4 and a padded 10/3 build).
module tb_nor_reduce_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, in_clr, out_valid, out_ready, y;
    logic [31:0] a;
    logic [1:0]  mode, y_mode;

    logic        in_valid2, in_ready2, out_valid2, y2;
    logic [9:0]  a2;
    logic [1:0]  y_mode2;

    int n_vec  = 0;
    int n_miss = 0;

    logic [31:0] va [8];
    logic [1:0]  vm [8];
    logic        vc [8];
    logic        vy [8];

    always #5 clk = ~clk;

    nor_reduce_pipe dut (
        .CLK(clk), .RST(rst), .IN_VALID(in_valid), .IN_READY(in_ready), .A(a),
        .MODE(mode), .IN_CLR(in_clr), .OUT_VALID(out_valid), .OUT_READY(out_ready),
        .Y(y), .Y_MODE(y_mode)
    );

    nor_reduce_pipe #(.WIDTH(10), .FANIN(3)) dut2 (
        .CLK(clk), .RST(rst), .IN_VALID(in_valid2), .IN_READY(in_ready2), .A(a2),
        .MODE(2'b00), .IN_CLR(1'b0), .OUT_VALID(out_valid2), .OUT_READY(1'b1),
        .Y(y2), .Y_MODE(y_mode2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Back-to-back operands va/vm/vc[0..n-1] with OUT_READY=1; result i appears after edge k+2.
    task automatic run_burst(input string tag, input int n);
        out_ready = 1'b1;
        for (int cyc = 0; cyc < n + 2; cyc++) begin
            if (cyc < n) begin
                in_valid = 1'b1;
                a        = va[cyc];
                mode     = vm[cyc];
                in_clr   = vc[cyc];
                check($sformatf("%s ready[%0d]", tag, cyc), in_ready, 1);
            end else begin
                in_valid = 1'b0;
                in_clr   = 1'b0;
            end
            step();
            if (cyc < 2) begin
                check($sformatf("%s early_valid[%0d]", tag, cyc), out_valid, 0);
            end else begin
                check($sformatf("%s valid[%0d]", tag, cyc - 2), out_valid, 1);
                check($sformatf("%s y[%0d]", tag, cyc - 2), y, vy[cyc-2]);
                check($sformatf("%s y_mode[%0d]", tag, cyc - 2), y_mode, vm[cyc-2]);
            end
        end
        step();
        check({tag, " drained"}, out_valid, 0);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; a = '0; mode = 2'b00; in_clr = 1'b0; out_ready = 1'b1;
        in_valid2 = 1'b0; a2 = '0;
        step();
        step();
        check("rst out_valid", out_valid, 0);
        check("rst y", y, 0);
        check("rst y_mode", y_mode, 0);
        check("rst in_ready", in_ready, 1);
        check("rst acc", dut.acc_q, 1);
        rst = 1'b0;

        // NOR: zero operand -> 1, single set bit -> 0
        va[0] = 32'h0;         vm[0] = 2'b00; vc[0] = 1'b0; vy[0] = 1'b1;
        va[1] = 32'h0000_0100; vm[1] = 2'b00; vc[1] = 1'b0; vy[1] = 1'b0;
        run_burst("nor", 2);

        // OR, plus reserved mode behaving as NOR
        va[0] = 32'h8000_0000; vm[0] = 2'b01; vc[0] = 1'b0; vy[0] = 1'b1;
        va[1] = 32'h0;         vm[1] = 2'b01; vc[1] = 1'b0; vy[1] = 1'b0;
        va[2] = 32'h0001_0000; vm[2] = 2'b01; vc[2] = 1'b0; vy[2] = 1'b1;
        va[3] = 32'h0;         vm[3] = 2'b11; vc[3] = 1'b0; vy[3] = 1'b1;
        va[4] = 32'h0000_0001; vm[4] = 2'b11; vc[4] = 1'b0; vy[4] = 1'b0;
        run_burst("or_rsvd", 5);

        // Sticky NOR: clear, hold, hit, stay low, clear again
        va[0] = 32'h0; vm[0] = 2'b10; vc[0] = 1'b1; vy[0] = 1'b1;
        va[1] = 32'h0; vm[1] = 2'b10; vc[1] = 1'b0; vy[1] = 1'b1;
        va[2] = 32'h4; vm[2] = 2'b10; vc[2] = 1'b0; vy[2] = 1'b0;
        va[3] = 32'h0; vm[3] = 2'b10; vc[3] = 1'b0; vy[3] = 1'b0;
        va[4] = 32'h0; vm[4] = 2'b10; vc[4] = 1'b1; vy[4] = 1'b1;
        run_burst("sticky", 5);

        // OR leaves ACC alone; IN_CLR on a NOR operand re-arms ACC
        va[0] = 32'h1; vm[0] = 2'b10; vc[0] = 1'b1; vy[0] = 1'b0;
        va[1] = 32'h1; vm[1] = 2'b01; vc[1] = 1'b0; vy[1] = 1'b1;
        va[2] = 32'h0; vm[2] = 2'b10; vc[2] = 1'b0; vy[2] = 1'b0;
        va[3] = 32'h0; vm[3] = 2'b00; vc[3] = 1'b1; vy[3] = 1'b1;
        va[4] = 32'h0; vm[4] = 2'b10; vc[4] = 1'b0; vy[4] = 1'b1;
        run_burst("acc_ctl", 5);

        // Stall: 6 cycles OUT_READY=0, three OR operands must fit, then drain in order
        va[0] = 32'h1; va[1] = 32'h0; va[2] = 32'h0001_0000; va[3] = 32'hFFFF_FFFF;
        vy[0] = 1'b1;  vy[1] = 1'b0;  vy[2] = 1'b1;
        begin
            int acc_cnt;
            acc_cnt   = 0;
            out_ready = 1'b0;
            in_valid  = 1'b1;
            mode      = 2'b01;
            in_clr    = 1'b0;
            for (int cyc = 0; cyc < 6; cyc++) begin
                a = va[acc_cnt];
                check($sformatf("stall ready[%0d]", cyc), in_ready, (acc_cnt < 3) ? 1 : 0);
                if (in_ready) acc_cnt++;
                step();
                if (cyc >= 2) begin
                    check($sformatf("stall valid[%0d]", cyc), out_valid, 1);
                    check($sformatf("stall y[%0d]", cyc), y, 1);
                end
            end
            in_valid  = 1'b0;
            out_ready = 1'b1;
            for (int i = 0; i < 3; i++) begin
                check($sformatf("drain valid[%0d]", i), out_valid, 1);
                check($sformatf("drain y[%0d]", i), y, vy[i]);
                check($sformatf("drain y_mode[%0d]", i), y_mode, 2'b01);
                step();
            end
            check("drain empty", out_valid, 0);
        end

        // Padded 10-bit / fanin-3 build: bit 9 sits in a partly padded group
        in_valid2 = 1'b1; a2 = 10'h200;
        step();
        a2 = 10'h000;
        check("w10 early0", out_valid2, 0);
        step();
        in_valid2 = 1'b0;
        check("w10 early1", out_valid2, 0);
        step();
        check("w10 valid0", out_valid2, 1);
        check("w10 y0", y2, 0);
        step();
        check("w10 y1", y2, 1);
        step();
        check("w10 drained", out_valid2, 0);

        // Drive ACC to 0, fill the stalled pipe, then reset asynchronously
        va[0] = 32'h1; vm[0] = 2'b10; vc[0] = 1'b1; vy[0] = 1'b0;
        run_burst("pre_rst", 1);
        check("pre_rst acc", dut.acc_q, 0);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        a         = 32'h0;
        mode      = 2'b10;
        in_clr    = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("fill ready[%0d]", i), in_ready, 1);
            step();
        end
        in_valid = 1'b0;
        check("fill full", in_ready, 0);
        check("fill valid", out_valid, 1);
        rst = 1'b1;
        #1;
        check("async out_valid", out_valid, 0);
        check("async y", y, 0);
        check("async y_mode", y_mode, 0);
        check("async in_ready", in_ready, 1);
        check("async acc", dut.acc_q, 1);
        step();
        step();
        rst       = 1'b0;
        out_ready = 1'b1;

        va[0] = 32'h0; vm[0] = 2'b10; vc[0] = 1'b0; vy[0] = 1'b1;
        run_burst("post_rst", 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
